// File: rtl/spi_slave_fifo.sv
// SPI slave oversampled in the i_Clk domain, with first-word-fall-through TX/RX FIFOs.
// Optional sticky error flags (o_Err, i_Err_Clr) are present when SPI_SLAVE_ERR_EN is defined.
module spi_slave_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst_L,
`ifdef SPI_SLAVE_ERR_EN
    output logic [2:0]                      o_Err,
    input  logic                            i_Err_Clr,
`endif
    input  logic [1:0]                      i_SPI_Mode,
    input  logic                            i_TX_DV,
    input  logic [DATA_WIDTH-1:0]           i_TX_Data,
    output logic                            o_TX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]     o_TX_Level,
    output logic                            o_RX_Valid,
    output logic [DATA_WIDTH-1:0]           o_RX_Data,
    input  logic                            i_RX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]     o_RX_Level,
    output logic                            o_Busy,
    input  logic                            i_SPI_Clk,
    input  logic                            i_SPI_MOSI,
    output logic                            o_SPI_MISO,
    input  logic                            i_SPI_CS_n
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, cs_sync_q, cs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    state_e                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic                   reload_q, reload_d, first_q, first_d;
    logic [DATA_WIDTH-1:0]  tx_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  rx_mem_q [FIFO_DEPTH];
    logic [LW-1:0]          tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
    logic lead_s, trail_s, sample_edge_s, shift_edge_s;
    logic [LW-1:0] tx_level_s, rx_level_s;
    logic tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic tx_wr_en_s, tx_load_s, rx_push_s, rx_wr_en_s, rx_pop_s;
    logic [DATA_WIDTH-1:0] tx_head_s, rx_word_s;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    assign cs_rise_s   = cs_s & ~cs_prev_q;
    assign cs_fall_s   = ~cs_s & cs_prev_q;

    // Edge roles come from the mode latched at CS fall, never the live input.
    assign lead_s        = mode_q[1] ? sclk_fall_s : sclk_rise_s;
    assign trail_s       = mode_q[1] ? sclk_rise_s : sclk_fall_s;
    assign sample_edge_s = mode_q[0] ? trail_s : lead_s;
    assign shift_edge_s  = mode_q[0] ? lead_s : trail_s;

    assign tx_level_s = tx_wr_q - tx_rd_q;
    assign rx_level_s = rx_wr_q - rx_rd_q;
    assign tx_full_s  = (tx_level_s == LW'(FIFO_DEPTH));
    assign tx_empty_s = (tx_level_s == {LW{1'b0}});
    assign rx_full_s  = (rx_level_s == LW'(FIFO_DEPTH));
    assign rx_empty_s = (rx_level_s == {LW{1'b0}});
    assign tx_wr_en_s = i_TX_DV & ~tx_full_s;
    assign rx_wr_en_s = rx_push_s & ~rx_full_s;
    assign rx_pop_s   = i_RX_Ready & ~rx_empty_s;
    assign tx_head_s  = tx_empty_s ? {DATA_WIDTH{1'b0}} : tx_mem_q[tx_rd_q[AW-1:0]];
    assign rx_word_s  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

    // Synchroniser chains and edge-detect history.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    // Transfer FSM: word framing, shift registers and FIFO push/pop requests.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        reload_d   = reload_q;
        first_d    = first_q;
        tx_load_s  = 1'b0;
        rx_push_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d    = ST_ACTIVE;
                    mode_d     = i_SPI_Mode;
                    cnt_d      = {CW{1'b0}};
                    rx_shift_d = {DATA_WIDTH{1'b0}};
                    tx_shift_d = tx_head_s;
                    tx_load_s  = 1'b1;
                    reload_d   = 1'b0;
                    first_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    state_d  = ST_IDLE;
                    cnt_d    = {CW{1'b0}};
                    reload_d = 1'b0;
                end else if (sample_edge_s) begin
                    rx_shift_d = rx_word_s;
                    first_d    = 1'b0;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        rx_push_s = 1'b1;
                        cnt_d     = {CW{1'b0}};
                        reload_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (shift_edge_s) begin
                    first_d = 1'b0;
                    // CPHA=1: the opening leading edge must not disturb the preloaded MSB.
                    if (mode_q[0] && first_q) begin
                        tx_shift_d = tx_shift_q;
                    end else if (reload_q) begin
                        tx_shift_d = tx_head_s;
                        tx_load_s  = 1'b1;
                        reload_d   = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    first_d = first_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer updates; pointers wrap naturally and level is their difference.
    always_comb begin
        if (tx_wr_en_s) begin
            tx_wr_d = tx_wr_q + LW'(1);
        end else begin
            tx_wr_d = tx_wr_q;
        end
        if (tx_load_s && !tx_empty_s) begin
            tx_rd_d = tx_rd_q + LW'(1);
        end else begin
            tx_rd_d = tx_rd_q;
        end
        if (rx_wr_en_s) begin
            rx_wr_d = rx_wr_q + LW'(1);
        end else begin
            rx_wr_d = rx_wr_q;
        end
        if (rx_pop_s) begin
            rx_rd_d = rx_rd_q + LW'(1);
        end else begin
            rx_rd_d = rx_rd_q;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            mode_q      <= 2'b00;
            cnt_q       <= {CW{1'b0}};
            rx_shift_q  <= {DATA_WIDTH{1'b0}};
            tx_shift_q  <= {DATA_WIDTH{1'b0}};
            reload_q    <= 1'b0;
            first_q     <= 1'b0;
            tx_wr_q     <= {LW{1'b0}};
            tx_rd_q     <= {LW{1'b0}};
            rx_wr_q     <= {LW{1'b0}};
            rx_rd_q     <= {LW{1'b0}};
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            reload_q    <= reload_d;
            first_q     <= first_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
        end
    end

    // FIFO storage; contents are only visible through the occupancy-gated head.
    always_ff @(posedge i_Clk) begin
        if (tx_wr_en_s) begin
            tx_mem_q[tx_wr_q[AW-1:0]] <= i_TX_Data;
        end
        if (rx_wr_en_s) begin
            rx_mem_q[rx_wr_q[AW-1:0]] <= rx_word_s;
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    logic [2:0] err_q, err_d, err_evt_s;

    assign err_evt_s = {(state_q == ST_ACTIVE) && cs_rise_s && (cnt_q != {CW{1'b0}}),
                        rx_push_s & rx_full_s,
                        tx_load_s & tx_empty_s};

    // Sticky flags: a new event wins over a same-cycle clear.
    always_comb begin
        if (i_Err_Clr) begin
            err_d = err_evt_s;
        end else begin
            err_d = err_q | err_evt_s;
        end
    end

    // Error flag register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            err_q <= 3'b000;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_Err = err_q;
`endif

    assign o_TX_Ready = ~tx_full_s;
    assign o_TX_Level = tx_level_s;
    assign o_RX_Valid = ~rx_empty_s;
    assign o_RX_Data  = rx_empty_s ? {DATA_WIDTH{1'b0}} : rx_mem_q[rx_rd_q[AW-1:0]];
    assign o_RX_Level = rx_level_s;
    assign o_Busy     = ~cs_s;
    assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : tx_shift_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Randomised bench for spi_slave_fifo: a bit-banged SPI master against a queue-based model
// of the TX/RX FIFOs and the word framing rules.
module tb_spi_slave_fifo;
    logic       clk = 1'b0;
    logic       i_Rst_L;
    logic [1:0] i_SPI_Mode;
    logic       i_TX_DV;
    logic [7:0] i_TX_Data;
    logic       o_TX_Ready;
    logic [2:0] o_TX_Level;
    logic       o_RX_Valid;
    logic [7:0] o_RX_Data;
    logic       i_RX_Ready;
    logic [2:0] o_RX_Level;
    logic       o_Busy;
    logic       i_SPI_Clk;
    logic       i_SPI_MOSI;
    logic       o_SPI_MISO;
    logic       i_SPI_CS_n;
`ifdef SPI_SLAVE_ERR_EN
    logic [2:0] o_Err;
    logic       i_Err_Clr = 1'b0;
`endif

    always #5 clk = ~clk;

    spi_slave_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .i_Clk(clk),
        .i_Rst_L(i_Rst_L),
`ifdef SPI_SLAVE_ERR_EN
        .o_Err(o_Err),
        .i_Err_Clr(i_Err_Clr),
`endif
        .i_SPI_Mode(i_SPI_Mode),
        .i_TX_DV(i_TX_DV),
        .i_TX_Data(i_TX_Data),
        .o_TX_Ready(o_TX_Ready),
        .o_TX_Level(o_TX_Level),
        .o_RX_Valid(o_RX_Valid),
        .o_RX_Data(o_RX_Data),
        .i_RX_Ready(i_RX_Ready),
        .o_RX_Level(o_RX_Level),
        .o_Busy(o_Busy),
        .i_SPI_Clk(i_SPI_Clk),
        .i_SPI_MOSI(i_SPI_MOSI),
        .o_SPI_MISO(o_SPI_MISO),
        .i_SPI_CS_n(i_SPI_CS_n)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] tx_m[$];
    logic [7:0] rx_m[$];
    logic [2:0] err_m = 3'b000;
    logic [7:0] mo_w[8];
    logic [7:0] mi_w[8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] w);
        @(negedge clk);
        i_TX_DV   = 1'b1;
        i_TX_Data = w;
        @(negedge clk);
        i_TX_DV   = 1'b0;
        if (tx_m.size() < 4) tx_m.push_back(w);
    endtask

    task automatic check_err();
`ifdef SPI_SLAVE_ERR_EN
        check_eq("err_flags", {29'd0, o_Err}, {29'd0, err_m});
        i_Err_Clr = 1'b1;
        @(negedge clk);
        i_Err_Clr = 1'b0;
        @(negedge clk);
        check_eq("err_cleared", {29'd0, o_Err}, 32'd0);
`endif
        err_m = 3'b000;
    endtask

    // One CS-framed transfer of nbits bits taken MSB-first from mo_w[], then the model update.
    task automatic spi_xfer(input logic [1:0] mode, input int nbits);
        logic cpol, cpha, bv;
        logic [7:0] e, mask;
        int w, b, nfull, k, nshow, pops;
        cpol = mode[1];
        cpha = mode[0];
        i_SPI_Mode = mode;
        i_SPI_Clk  = cpol;
        half();
        i_SPI_CS_n = 1'b0;
        half();
        check_eq("busy_active", {31'd0, o_Busy}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            w  = i / 8;
            b  = 7 - (i % 8);
            bv = mo_w[w][b];
            if (!cpha) begin
                i_SPI_MOSI = bv;
                half();
                mi_w[w][b] = o_SPI_MISO;
                i_SPI_Clk  = ~cpol;
                half();
                i_SPI_Clk  = cpol;
            end else begin
                i_SPI_Clk  = ~cpol;
                i_SPI_MOSI = bv;
                half();
                mi_w[w][b] = o_SPI_MISO;
                i_SPI_Clk  = cpol;
                half();
            end
        end
        half();
        i_SPI_CS_n = 1'b1;
        half();
        nfull = nbits / 8;
        k     = nbits % 8;
        nshow = (nbits + 7) / 8;
        // TX words leave the FIFO at CS fall and at each reload shift edge that the master produced.
        pops  = cpha ? ((nshow > 0) ? nshow : 1) : nfull + 1;
        for (int j = 0; j < pops; j++) begin
            e = 8'h00;
            if (tx_m.size() > 0) e = tx_m.pop_front();
            else err_m[0] = 1'b1;
            if (j < nshow) begin
                mask = 8'hFF;
                if (j == nfull) mask = mask << (8 - k);
                check_eq("miso_word", {24'd0, mi_w[j] & mask}, {24'd0, e & mask});
            end
        end
        for (int j = 0; j < nfull; j++) begin
            if (rx_m.size() < 4) rx_m.push_back(mo_w[j]);
            else err_m[1] = 1'b1;
        end
        if (k != 0) err_m[2] = 1'b1;
        check_eq("busy_idle", {31'd0, o_Busy}, 32'd0);
        check_eq("tx_level", {29'd0, o_TX_Level}, tx_m.size());
        check_eq("rx_level", {29'd0, o_RX_Level}, rx_m.size());
        check_err();
    endtask

    task automatic drain();
        logic [7:0] e;
        while (rx_m.size() > 0) begin
            e = rx_m.pop_front();
            check_eq("rx_valid", {31'd0, o_RX_Valid}, 32'd1);
            check_eq("rx_data", {24'd0, o_RX_Data}, {24'd0, e});
            i_RX_Ready = 1'b1;
            @(negedge clk);
            i_RX_Ready = 1'b0;
        end
        check_eq("rx_drained", {31'd0, o_RX_Valid}, 32'd0);
        check_eq("rx_level_0", {29'd0, o_RX_Level}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_ready"}, {31'd0, o_TX_Ready}, 32'd1);
        check_eq({tag, "_tx_level"}, {29'd0, o_TX_Level}, 32'd0);
        check_eq({tag, "_rx_valid"}, {31'd0, o_RX_Valid}, 32'd0);
        check_eq({tag, "_rx_data"}, {24'd0, o_RX_Data}, 32'd0);
        check_eq({tag, "_rx_level"}, {29'd0, o_RX_Level}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, o_Busy}, 32'd0);
`ifdef SPI_SLAVE_ERR_EN
        check_eq({tag, "_err"}, {29'd0, o_Err}, 32'd0);
`endif
    endtask

    initial begin
        logic [1:0] m;
        int nw, nb;
        i_Rst_L    = 1'b0;
        i_SPI_Mode = 2'b00;
        i_TX_DV    = 1'b0;
        i_TX_Data  = 8'h00;
        i_RX_Ready = 1'b0;
        i_SPI_Clk  = 1'b0;
        i_SPI_MOSI = 1'b0;
        i_SPI_CS_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        i_Rst_L = 1'b1;
        @(negedge clk);

        // Mode 0 single word.
        tx_write(8'hA5);
        check_eq("tx_level_1", {29'd0, o_TX_Level}, 32'd1);
        mo_w[0] = 8'h3C;
        spi_xfer(2'd0, 8);
        drain();

        // Modes 1..3 with the same pattern.
        for (int md = 1; md < 4; md++) begin
            tx_write(8'h81);
            mo_w[0] = 8'h7E;
            spi_xfer(md[1:0], 8);
            drain();
        end

        // Three-word burst under one CS.
        tx_write(8'h11); tx_write(8'h22); tx_write(8'h33);
        mo_w[0] = 8'h01; mo_w[1] = 8'h02; mo_w[2] = 8'h03;
        spi_xfer(2'd0, 24);
        drain();

        // TX full, RX overflow and TX underflow.
        for (int i = 0; i < 5; i++) tx_write(8'($urandom));
        check_eq("tx_full_level", {29'd0, o_TX_Level}, 32'd4);
        check_eq("tx_full_ready", {31'd0, o_TX_Ready}, 32'd0);
        for (int i = 0; i < 5; i++) mo_w[i] = 8'($urandom);
        spi_xfer(2'($urandom_range(0, 3)), 40);
        drain();

        // CS abort after 5 bits, then a clean word.
        m = 2'($urandom_range(0, 3));
        tx_write(8'hC7);
        mo_w[0] = 8'($urandom);
        spi_xfer(m, 5);
        tx_write(8'h5E);
        mo_w[0] = 8'hD2;
        spi_xfer(m, 8);
        drain();

        // Random transfers, including partial words.
        for (int it = 0; it < 20; it++) begin
            m  = 2'($urandom_range(0, 3));
            nw = $urandom_range(0, 3);
            nb = $urandom_range(1, 24);
            for (int i = 0; i < nw; i++) tx_write(8'($urandom));
            for (int i = 0; i < 3; i++) mo_w[i] = 8'($urandom);
            spi_xfer(m, nb);
            drain();
        end

        // Asynchronous reset in the middle of a word.
        tx_write(8'h5A); tx_write(8'hC3);
        i_SPI_Mode = 2'b00;
        i_SPI_Clk  = 1'b0;
        half();
        i_SPI_CS_n = 1'b0;
        half();
        for (int i = 0; i < 3; i++) begin
            i_SPI_MOSI = 1'b1;
            half();
            i_SPI_Clk = 1'b1;
            half();
            i_SPI_Clk = 1'b0;
        end
        check_eq("mid_tx_level", {29'd0, o_TX_Level}, 32'd1);
        check_eq("mid_busy", {31'd0, o_Busy}, 32'd1);
        i_Rst_L = 1'b0;
        #1;
        check_reset_outputs("midrst");
        i_SPI_CS_n = 1'b1;
        tx_m.delete();
        rx_m.delete();
        err_m = 3'b000;
        repeat (4) @(negedge clk);
        i_Rst_L = 1'b1;
        @(negedge clk);
        tx_write(8'h96);
        mo_w[0] = 8'h69;
        spi_xfer(2'd0, 8);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
